paddle_game_ctrl: RTL



---
 rtl/breakout_pkg.sv | 14 +
 rtl/paddle_pos.sv | 54 +++++
 rtl/paddle_game_ctrl.sv | 101 ++++++++++
 3 files changed

// File: rtl/breakout_pkg.sv
// Shared game-state encoding and screen geometry defaults for the breakout datapath.
package breakout_pkg;

  typedef enum logic [1:0] {
    S_SERVE = 2'd0,
    S_PLAY  = 2'd1,
    S_OVER  = 2'd2,
    S_WIN   = 2'd3
  } game_state_e;

  localparam int unsigned SCREEN_W_DEF = 640;
  localparam int unsigned PADDLE_W_DEF = 80;

endpackage

// File: rtl/paddle_pos.sv
// Clamped paddle left-edge register: steps left/right, saturates at 0 and at the right limit.
module paddle_pos
  import breakout_pkg::*;
#(
  parameter int unsigned SCREEN_W = SCREEN_W_DEF,
  parameter int unsigned PADDLE_W = PADDLE_W_DEF,
  parameter int unsigned STEP     = 16,
  parameter int unsigned XW       = 10
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          en,
  input  logic          left,
  input  logic          right,
  input  logic          load_init,
  output logic [XW-1:0] x
);

  localparam logic [XW:0]   XMax  = (XW+1)'(SCREEN_W - PADDLE_W);
  localparam logic [XW:0]   StepW = (XW+1)'(STEP);
  localparam logic [XW-1:0] XInit = XW'((SCREEN_W - PADDLE_W) / 2);

  logic [XW-1:0] x_q, x_d;
  logic [XW:0]   x_ext, sum, diff;

  // One extra bit keeps x + STEP from wrapping before the clamp compare.
  assign x_ext = {1'b0, x_q};
  assign sum   = x_ext + StepW;
  assign diff  = x_ext - StepW;

  always_comb begin
    x_d = x_q;
    if (load_init) begin
      x_d = XInit;
    end else if (en && (left ^ right)) begin
      if (left) begin
        x_d = (x_ext < StepW) ? '0 : diff[XW-1:0];
      end else begin
        x_d = (sum > XMax) ? XMax[XW-1:0] : sum[XW-1:0];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      x_q <= XInit;
    end else begin
      x_q <= x_d;
    end
  end

  assign x = x_q;

endmodule

// File: rtl/paddle_game_ctrl.sv
// Top-level game FSM (serve/play/over/win), lives counter and paddle position; outputs registered.
module paddle_game_ctrl
  import breakout_pkg::*;
#(
  parameter int unsigned SCREEN_W = SCREEN_W_DEF,
  parameter int unsigned PADDLE_W = PADDLE_W_DEF,
  parameter int unsigned STEP     = 16,
  parameter int unsigned XW       = 10,
  parameter int unsigned LIVES    = 3
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          left_pulse,
  input  logic          right_pulse,
  input  logic          launch_pulse,
  input  logic          ball_lost,
  input  logic          bricks_cleared,
  output logic [XW-1:0] paddle_x,
  output logic [1:0]    game_state,
  output logic [1:0]    lives,
  output logic          serve
);

  game_state_e state_q, state_d;
  logic [1:0]  lives_q, lives_d;
  logic        serve_q, serve_d;
  logic        move_en;
  logic        restart;

  assign move_en = (state_q == S_SERVE) || (state_q == S_PLAY);
  assign restart = launch_pulse && ((state_q == S_OVER) || (state_q == S_WIN));

  paddle_pos #(
    .SCREEN_W (SCREEN_W),
    .PADDLE_W (PADDLE_W),
    .STEP     (STEP),
    .XW       (XW)
  ) u_paddle_pos (
    .clock     (clock),
    .reset     (reset),
    .en        (move_en),
    .left      (left_pulse),
    .right     (right_pulse),
    .load_init (restart),
    .x         (paddle_x)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_SERVE;
      lives_q <= 2'(LIVES);
      serve_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lives_q <= lives_d;
      serve_q <= serve_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    serve_d = 1'b0;
    case (state_q)
      S_SERVE: begin
        if (launch_pulse) begin
          state_d = S_PLAY;
          serve_d = 1'b1;
        end
      end
      S_PLAY: begin
        // A cleared board wins even if the ball is lost in the same cycle.
        if (bricks_cleared) begin
          state_d = S_WIN;
        end else if (ball_lost) begin
          if (lives_q > 2'd1) begin
            lives_d = lives_q - 2'd1;
            state_d = S_SERVE;
          end else begin
            lives_d = 2'd0;
            state_d = S_OVER;
          end
        end
      end
      S_OVER, S_WIN: begin
        if (launch_pulse) begin
          lives_d = 2'(LIVES);
          state_d = S_SERVE;
        end
      end
      default: state_d = S_SERVE;
    endcase
  end

  always_comb begin
    game_state = state_q;
    lives      = lives_q;
    serve      = serve_q;
  end

endmodule
